// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller for a classic 5-stage in-order core.
//   It resolves three kinds of hazard and drives the stall and flush
//   controls of the front end.
//     - Load-use: the instruction in ID reads the destination of a load in EX.
//       The PC and IF/ID are held and a bubble goes into ID/EX.
//     - Taken redirect: a branch or jump resolves taken in EX. The younger
//       instructions are flushed for BR_FLUSH_CYC cycles.
//     - Memory wait: mem_busy freezes the whole pipeline.
//   A sticky timeout flag catches a memory that never answers.
//
//   Priority: mem_busy > ex_branch_taken > REDIRECT-state flush > load_use.
//   The state is registered. All stall and flush outputs are combinational
//   from the state and the inputs, so they act in the same cycle.
//
//   Handshake note: there is no valid/ready pair on this block. The stall
//   and flush outputs are level enables that apply in the cycle they are
//   asserted. The rest of the pipeline samples them on the same rising edge.
//
// Parameters
//   BR_FLUSH_CYC  1 or 2. Number of cycles if_id_flush is high per redirect.
//   MEM_TIMEOUT   0..255. Consecutive busy cycles that set err_timeout.
//                 0 disables the timeout.
//   CNT_W         Width of the performance counters.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   id_rs1/id_rs2 (+_used)     sources of the ID instruction
//   ex_rd, ex_mem_read         destination of the EX instruction, and
//                              whether that instruction is a load
//   ex_branch_taken            PC redirect resolved in EX
//   mem_busy                   data memory is not ready
//   pc_write, if_id_write      PC and IF/ID write enables
//   if_id_flush, id_ex_flush   load a bubble into IF/ID or ID/EX
//   ex_mem_hold                hold EX/MEM and MEM/WB
//   err_timeout                sticky memory-wait timeout
//   state_dbg                  current FSM state (0 RUN, 1 MEM_WAIT, 2 REDIRECT)
//   stall_cnt, flush_cnt       performance counters; these ports exist only
//                              when HAZARD_PERF_CNT_EN is defined
//
// Build option: define HAZARD_PERF_CNT_EN to add the performance counters.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int BR_FLUSH_CYC = 1,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_hold,
    output logic             err_timeout,
    output logic [1:0]       state_dbg
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    // Reject illegal parameter values when the design is elaborated.
    if (BR_FLUSH_CYC != 1 && BR_FLUSH_CYC != 2) begin : g_bad_br_flush
        $error("hazard_ctrl: BR_FLUSH_CYC must be 1 or 2");
    end
    if (MEM_TIMEOUT < 0 || MEM_TIMEOUT > 255) begin : g_bad_timeout
        $error("hazard_ctrl: MEM_TIMEOUT must be 0..255");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("hazard_ctrl: CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nxt;
    logic       load_use;
    logic       timeout_hit;

    assign state_dbg = state;

    // The ID instruction needs a value that the load in EX has not produced
    // yet. x0 is hard-wired to zero, so it never creates a dependency.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

    // Combinational outputs and next state, in priority order.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_hold = 1'b0;
        state_nxt   = ST_RUN;
        if (rst) begin
            // Keep the front end inert and full of bubbles while in reset.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_nxt   = ST_RUN;
        end else if (mem_busy) begin
            // Freeze everything. A pending redirect is kept and resumes
            // once memory is ready. A branch seen now is deferred, because
            // the held EX stage presents it again.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_mem_hold = 1'b1;
            state_nxt   = (state == ST_REDIRECT) ? ST_REDIRECT : ST_MEM_WAIT;
        end else if (ex_branch_taken) begin
            // A taken redirect discards any load-use stall in the same
            // cycle. It also restarts a redirect that is already running.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_nxt   = (BR_FLUSH_CYC == 2) ? ST_REDIRECT : ST_RUN;
        end else if (state == ST_REDIRECT) begin
            // Second flush cycle. This covers a registered instruction memory.
            if_id_flush = 1'b1;
            state_nxt   = ST_RUN;
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            state_nxt   = ST_RUN;
        end
    end

    // Count consecutive busy cycles, saturating at 255.
    always_comb begin
        wait_cnt_nxt = 8'd0;
        if (mem_busy) begin
            wait_cnt_nxt = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;
        end
    end

    // The flag sets on the same edge at which the count reaches MEM_TIMEOUT.
    // It is therefore visible in the cycle after the count gets there.
    assign timeout_hit = (MEM_TIMEOUT != 0) && mem_busy && (wait_cnt_nxt >= TMO);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            wait_cnt    <= 8'd0;
            err_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Free-running, wrapping event counters. They are cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (if_id_flush) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
